task3: RTL and testbench



---
 rtl/task3.sv | 273 +++++++++++++++++++++++++++
 tb/tb_task3.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/task3.sv
// task3: clears the 160x120 framebuffer to black, then draws one green
// midpoint circle (centre 80,60, radius 40) through the VGA adapter.

module vga_adapter (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic [7:0] vga_r,
    output logic [7:0] vga_g,
    output logic [7:0] vga_b,
    output logic       vga_hs,
    output logic       vga_vs,
    output logic       vga_clk
);
    localparam int unsigned AW      = 15;
    localparam int unsigned DEPTH   = 19200;
    localparam int unsigned FB_H    = 120;
    localparam int unsigned H_TOTAL = 800;
    localparam int unsigned V_TOTAL = 525;

    logic [2:0]    fb_mem [DEPTH];
    logic [AW-1:0] wr_addr;
    logic [AW-1:0] rd_addr;
    logic [9:0]    hcnt;
    logic [9:0]    vcnt;
    logic          pix_en;
    logic          active;
    logic [2:0]    pix_q;
    logic          unused_cnt;

    assign wr_addr    = AW'(x) * AW'(FB_H) + AW'(y);
    assign rd_addr    = AW'(hcnt[9:2]) * AW'(FB_H) + AW'(vcnt[9:2]);
    assign active     = (hcnt < 10'd640) && (vcnt < 10'd480);
    assign unused_cnt = ^{hcnt[1:0], vcnt[1:0]};

    // Framebuffer write port: one pixel per rising edge while plot is high.
    always_ff @(posedge clk) begin
        if (plot && (wr_addr < AW'(DEPTH))) begin
            fb_mem[wr_addr] <= colour;
        end
    end

    // 640x480 scan at half the system clock; each framebuffer pixel is a 4x4 block.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pix_en  <= 1'b0;
            hcnt    <= '0;
            vcnt    <= '0;
            pix_q   <= '0;
            vga_r   <= '0;
            vga_g   <= '0;
            vga_b   <= '0;
            vga_hs  <= 1'b1;
            vga_vs  <= 1'b1;
            vga_clk <= 1'b0;
        end else begin
            pix_en  <= ~pix_en;
            vga_clk <= pix_en;
            if (pix_en) begin
                if (hcnt == 10'(H_TOTAL - 1)) begin
                    hcnt <= '0;
                    vcnt <= (vcnt == 10'(V_TOTAL - 1)) ? '0 : vcnt + 10'd1;
                end else begin
                    hcnt <= hcnt + 10'd1;
                end
                pix_q  <= active ? fb_mem[rd_addr] : 3'b000;
                vga_r  <= {8{pix_q[2]}};
                vga_g  <= {8{pix_q[1]}};
                vga_b  <= {8{pix_q[0]}};
                vga_hs <= ~((hcnt >= 10'd656) && (hcnt < 10'd752));
                vga_vs <= ~((vcnt >= 10'd490) && (vcnt < 10'd492));
            end
        end
    end
endmodule

module task3 (
    input  logic       CLOCK_50,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5,
    output logic [7:0] VGA_R,
    output logic [7:0] VGA_G,
    output logic [7:0] VGA_B,
    output logic       VGA_HS,
    output logic       VGA_VS,
    output logic       VGA_CLK,
    output logic [7:0] VGA_X,
    output logic [6:0] VGA_Y,
    output logic [2:0] VGA_COLOUR,
    output logic       VGA_PLOT
);
    localparam int unsigned CW = 11;
    localparam logic [7:0] X_LAST = 8'd159;
    localparam logic [6:0] Y_LAST = 7'd119;
    localparam logic [2:0] BLACK  = 3'b000;
    localparam logic [2:0] GREEN  = 3'b010;
    localparam logic signed [CW-1:0] CX_S   = 11'sd80;
    localparam logic signed [CW-1:0] CY_S   = 11'sd60;
    localparam logic signed [CW-1:0] RAD_S  = 11'sd40;
    localparam logic signed [CW-1:0] ZERO_S = 11'sd0;
    localparam logic signed [CW-1:0] ONE_S  = 11'sd1;
    localparam logic signed [CW-1:0] XLIM_S = 11'sd160;
    localparam logic signed [CW-1:0] YLIM_S = 11'sd120;

    typedef enum logic [2:0] {
        S_FILL, S_GAP1, S_GAP2, S_GAP3, S_CIRCLE, S_DONE
    } state_t;

    logic          rst;
    state_t        state, state_nx;
    logic [7:0]    fx;
    logic [6:0]    fy;
    logic [2:0]    oct;
    logic signed [CW-1:0] ox, oy, crit;
    logic signed [CW-1:0] oy_inc, ox_nx, crit_nx;
    logic signed [CW-1:0] px_s, py_s;
    logic          in_range;
    logic [7:0]    hold_x;
    logic [6:0]    hold_y;
    logic [2:0]    hold_c;
    logic          unused_in;

    assign rst       = KEY[3];
    assign unused_in = ^{KEY[2:0], SW};
    assign LEDR      = '0;
    assign HEX0      = 7'b1111111;
    assign HEX1      = 7'b1111111;
    assign HEX2      = 7'b1111111;
    assign HEX3      = 7'b1111111;
    assign HEX4      = 7'b1111111;
    assign HEX5      = 7'b1111111;

    // Octant decode of the current circle point plus the end-of-iteration update.
    always_comb begin
        px_s = CX_S;
        py_s = CY_S;
        case (oct)
            3'd0: begin px_s = CX_S + ox; py_s = CY_S + oy; end
            3'd1: begin px_s = CX_S + oy; py_s = CY_S + ox; end
            3'd2: begin px_s = CX_S - ox; py_s = CY_S + oy; end
            3'd3: begin px_s = CX_S - oy; py_s = CY_S + ox; end
            3'd4: begin px_s = CX_S - ox; py_s = CY_S - oy; end
            3'd5: begin px_s = CX_S - oy; py_s = CY_S - ox; end
            3'd6: begin px_s = CX_S + ox; py_s = CY_S - oy; end
            default: begin px_s = CX_S + oy; py_s = CY_S - ox; end
        endcase
        in_range = (px_s >= ZERO_S) && (px_s < XLIM_S) &&
                   (py_s >= ZERO_S) && (py_s < YLIM_S);
        oy_inc = oy + ONE_S;
        if (crit <= ZERO_S) begin
            ox_nx   = ox;
            crit_nx = crit + (oy_inc <<< 1) + ONE_S;
        end else begin
            ox_nx   = ox - ONE_S;
            crit_nx = crit + ((oy_inc - ox_nx) <<< 1) + ONE_S;
        end
    end

    // Top-level state register.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            state <= S_FILL;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state and pixel-interface decode.
    always_comb begin
        state_nx   = state;
        VGA_X      = hold_x;
        VGA_Y      = hold_y;
        VGA_COLOUR = hold_c;
        VGA_PLOT   = 1'b0;
        case (state)
            S_FILL: begin
                VGA_X      = fx;
                VGA_Y      = fy;
                VGA_COLOUR = BLACK;
                VGA_PLOT   = 1'b1;
                if ((fx == X_LAST) && (fy == Y_LAST)) begin
                    state_nx = S_GAP1;
                end
            end
            S_GAP1: state_nx = S_GAP2;
            S_GAP2: state_nx = S_GAP3;
            S_GAP3: state_nx = S_CIRCLE;
            S_CIRCLE: begin
                VGA_X      = px_s[7:0];
                VGA_Y      = py_s[6:0];
                VGA_COLOUR = GREEN;
                VGA_PLOT   = in_range;
                if ((oct == 3'd7) && (oy_inc > ox_nx)) begin
                    state_nx = S_DONE;
                end
            end
            default: state_nx = S_DONE;
        endcase
    end

    // Fill scan counters, circle iterators and last-pixel hold registers.
    always_ff @(posedge CLOCK_50 or posedge rst) begin
        if (rst) begin
            fx     <= '0;
            fy     <= '0;
            oct    <= '0;
            ox     <= '0;
            oy     <= '0;
            crit   <= '0;
            hold_x <= '0;
            hold_y <= '0;
            hold_c <= '0;
        end else begin
            case (state)
                S_FILL: begin
                    hold_x <= VGA_X;
                    hold_y <= VGA_Y;
                    hold_c <= VGA_COLOUR;
                    if (fy == Y_LAST) begin
                        fy <= '0;
                        fx <= (fx == X_LAST) ? '0 : fx + 8'd1;
                    end else begin
                        fy <= fy + 7'd1;
                    end
                end
                S_GAP3: begin
                    ox   <= RAD_S;
                    oy   <= ZERO_S;
                    crit <= ONE_S - RAD_S;
                    oct  <= '0;
                end
                S_CIRCLE: begin
                    hold_x <= VGA_X;
                    hold_y <= VGA_Y;
                    hold_c <= VGA_COLOUR;
                    oct    <= oct + 3'd1;
                    if (oct == 3'd7) begin
                        oy   <= oy_inc;
                        ox   <= ox_nx;
                        crit <= crit_nx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Physical VGA output through the framebuffer adapter.
    vga_adapter u_vga (
        .clk     (CLOCK_50),
        .rst     (rst),
        .x       (VGA_X),
        .y       (VGA_Y),
        .colour  (VGA_COLOUR),
        .plot    (VGA_PLOT),
        .vga_r   (VGA_R),
        .vga_g   (VGA_G),
        .vga_b   (VGA_B),
        .vga_hs  (VGA_HS),
        .vga_vs  (VGA_VS),
        .vga_clk (VGA_CLK)
    );
endmodule

// File: tb/tb_task3.sv
// Scoreboard bench for task3: a reference model of fill + midpoint circle
// fills a queue of expected per-cycle pixels; a monitor pops one per cycle.

module tb_task3;
    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] ledr;
    logic [6:0] hex0, hex1, hex2, hex3, hex4, hex5;
    logic [7:0] vga_r, vga_g, vga_b;
    logic       vga_hs, vga_vs, vga_clk;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       vga_plot;

    typedef struct {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] c;
        logic       p;
        bit         chk_xy;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   idx    = 0;

    always #10 clk = ~clk;

    task3 dut (
        .CLOCK_50   (clk),
        .KEY        ({rst, 3'b000}),
        .SW         (10'd0),
        .LEDR       (ledr),
        .HEX0       (hex0),
        .HEX1       (hex1),
        .HEX2       (hex2),
        .HEX3       (hex3),
        .HEX4       (hex4),
        .HEX5       (hex5),
        .VGA_R      (vga_r),
        .VGA_G      (vga_g),
        .VGA_B      (vga_b),
        .VGA_HS     (vga_hs),
        .VGA_VS     (vga_vs),
        .VGA_CLK    (vga_clk),
        .VGA_X      (vga_x),
        .VGA_Y      (vga_y),
        .VGA_COLOUR (vga_colour),
        .VGA_PLOT   (vga_plot)
    );

    function automatic exp_t mk(int x, int y, logic [2:0] c, logic p, bit chk);
        exp_t e;
        e.x = 8'(x);
        e.y = 7'(y);
        e.c = c;
        e.p = p;
        e.chk_xy = chk;
        return e;
    endfunction

    // Reference model: the whole expected pixel stream after a reset release.
    task automatic push_run();
        int ox, oy, crit, lx, ly;
        int px[8];
        int py[8];
        for (int i = 0; i < 160; i++)
            for (int j = 0; j < 120; j++)
                q.push_back(mk(i, j, 3'b000, 1'b1, 1'b1));
        for (int g = 0; g < 3; g++)
            q.push_back(mk(0, 0, 3'b000, 1'b0, 1'b0));
        ox = 40; oy = 0; crit = 1 - 40; lx = 0; ly = 0;
        while (oy <= ox) begin
            px = '{80 + ox, 80 + oy, 80 - ox, 80 - oy, 80 - ox, 80 - oy, 80 + ox, 80 + oy};
            py = '{60 + oy, 60 + ox, 60 + oy, 60 + ox, 60 - oy, 60 - ox, 60 - oy, 60 - ox};
            for (int k = 0; k < 8; k++) begin
                q.push_back(mk(px[k], py[k], 3'b010,
                    (px[k] >= 0 && px[k] < 160 && py[k] >= 0 && py[k] < 120), 1'b1));
                lx = px[k];
                ly = py[k];
            end
            oy = oy + 1;
            if (crit <= 0) begin
                crit = crit + 2 * oy + 1;
            end else begin
                ox = ox - 1;
                crit = crit + 2 * (oy - ox) + 1;
            end
        end
        for (int d = 0; d < 1000; d++)
            q.push_back(mk(lx, ly, 3'b010, 1'b0, 1'b1));
    endtask

    // Assert reset for `hold` edges (called just after a rising edge), then release.
    task automatic do_reset(int hold);
        rst = 1'b1;
        q.delete();
        for (int h = 0; h < hold; h++)
            q.push_back(mk(0, 0, 3'b000, 1'b1, 1'b1));
        repeat (hold) @(posedge clk);
        #1;
        rst = 1'b0;
        idx = 0;
        push_run();
    endtask

    // Monitor: one expected entry per cycle, sampled mid-cycle.
    always @(negedge clk) begin
        exp_t e;
        int dx, dy;
        if (q.size() > 0) begin
            e = q.pop_front();
            checks++;
            if (!((vga_plot === e.p) &&
                  (!e.chk_xy || ((vga_x === e.x) && (vga_y === e.y) && (vga_colour === e.c))))) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL pixel[%0d] rst=%0b got x=%0d y=%0d c=%0d p=%0b expected x=%0d y=%0d c=%0d p=%0b (xy checked=%0b)",
                             idx, rst, vga_x, vga_y, vga_colour, vga_plot, e.x, e.y, e.c, e.p, e.chk_xy);
            end
            idx++;
        end
        if (vga_plot === 1'b1 && vga_colour === 3'b010) begin
            dx = int'(vga_x) - 80;
            dy = int'(vga_y) - 60;
            checks++;
            if (dx > 40 || dx < -40 || dy > 40 || dy < -40) begin
                errors++;
                if (errors <= 20)
                    $display("FAIL radius_bound got (%0d,%0d) required |dx|,|dy| <= 40 from (80,60)",
                             vga_x, vga_y);
            end
        end
    end

    initial begin
        int off;
        rst = 1'b1;
        @(posedge clk);
        #1;

        // Full run from reset.
        do_reset(int'($urandom_range(1, 3)));
        for (int n = 0; n < 30000 && q.size() > 0; n++) @(posedge clk);
        #1;

        // Reset in the middle of circle iteration 5, then a complete rerun.
        do_reset(int'($urandom_range(1, 3)));
        off = int'($urandom_range(0, 7));
        repeat (19235 + off) @(posedge clk);
        #1;
        do_reset(int'($urandom_range(1, 3)));
        for (int n = 0; n < 30000 && q.size() > 0; n++) @(posedge clk);
        #1;

        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d entries left required 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
